// File: rtl/pe.sv
// Signed multiply-accumulate processing element for a systolic array.
// Operands are forwarded right/down through one register stage; the accumulator wraps modulo 2^ACC.
module pe #(
   parameter int WIDTH = 8,
   parameter int ACC   = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic signed [WIDTH-1:0] a_in,
   input  logic signed [WIDTH-1:0] b_in,
   output logic signed [WIDTH-1:0] a_out,
   output logic signed [WIDTH-1:0] b_out,
   output logic signed [ACC-1:0]   acc_out
);

   if (WIDTH < 2) begin : g_bad_width
      $error("pe: WIDTH must be at least 2");
   end
   if (ACC < 2 * WIDTH) begin : g_bad_acc
      $error("pe: ACC must be at least 2*WIDTH");
   end

   // Full-precision product, sign-extended, added with silent two's-complement wrap.
   function automatic logic signed [ACC-1:0] mac_wrap(
      input logic signed [ACC-1:0]   acc,
      input logic signed [WIDTH-1:0] a,
      input logic signed [WIDTH-1:0] b
   );
      logic signed [2*WIDTH-1:0] prod;
      logic signed [ACC-1:0]     prod_ext;
      prod     = a * b;
      prod_ext = ACC'(prod);
      return acc + prod_ext;
   endfunction

   logic signed [WIDTH-1:0] a_q, a_d;
   logic signed [WIDTH-1:0] b_q, b_d;
   logic signed [ACC-1:0]   acc_q, acc_d;

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      if (en) begin
         a_d   = a_in;
         b_d   = b_in;
         acc_d = mac_wrap(acc_q, a_in, b_in);
      end
   end

   // Reset port keeps its legacy name but is active-high.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
      end
   end

   assign a_out   = a_q;
   assign b_out   = b_q;
   assign acc_out = acc_q;

endmodule

// File: tb/tb_pe.sv
// Bench for pe: directed scenarios plus randomized traffic against an integer reference model.
// Two instances share inputs: default (8/32) and a narrow-accumulator one (8/16) for wrap behaviour.
module tb_pe;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en;
   logic signed [7:0] a_in;
   logic signed [7:0] b_in;
   logic signed [7:0] a_out, b_out, a_out_w, b_out_w;
   logic signed [31:0] acc_out;
   logic signed [15:0] acc_out_w;

   int checks = 0;
   int errors = 0;

   longint ref_a, ref_b, ref_acc32, ref_acc16;

   always #5 clk = ~clk;

   pe #(.WIDTH(8), .ACC(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .a_in(a_in), .b_in(b_in),
      .a_out(a_out), .b_out(b_out), .acc_out(acc_out)
   );

   pe #(.WIDTH(8), .ACC(16)) u_wrap (
      .clk(clk), .rst_n(rst_n), .en(en), .a_in(a_in), .b_in(b_in),
      .a_out(a_out_w), .b_out(b_out_w), .acc_out(acc_out_w)
   );

   function automatic longint wrapn(input longint v, input int n);
      longint m;
      longint r;
      m = longint'(1) << n;
      r = v % m;
      if (r < 0) r += m;
      if (r >= m / 2) r -= m;
      return r;
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one edge; xin=1 drives unknown operands. Model updated from the values driven.
   task automatic step(input logic r, input logic e, input int a, input int b, input bit xin);
      rst_n = r;
      en    = e;
      if (xin) begin
         a_in = 'x;
         b_in = 'x;
      end else begin
         a_in = 8'(a);
         b_in = 8'(b);
      end
      @(posedge clk);
      #1;
      if (r) begin
         ref_a = 0; ref_b = 0; ref_acc32 = 0; ref_acc16 = 0;
      end else if (e) begin
         ref_a     = a;
         ref_b     = b;
         ref_acc32 = wrapn(ref_acc32 + longint'(a) * longint'(b), 32);
         ref_acc16 = wrapn(ref_acc16 + longint'(a) * longint'(b), 16);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_a"},     a_out,     ref_a);
      chk({tag, "_b"},     b_out,     ref_b);
      chk({tag, "_acc"},   acc_out,   ref_acc32);
      chk({tag, "_a_w"},   a_out_w,   ref_a);
      chk({tag, "_b_w"},   b_out_w,   ref_b);
      chk({tag, "_acc_w"}, acc_out_w, ref_acc16);
   endtask

   initial begin
      int ra, rb;
      logic rr, re;
      ref_a = 0; ref_b = 0; ref_acc32 = 0; ref_acc16 = 0;
      rst_n = 1'b1; en = 1'b0; a_in = '0; b_in = '0;

      // 1. reset dominates enable
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 5, 7, 1'b0);
         chk("rst_a", a_out, 0);
         chk("rst_b", b_out, 0);
         chk("rst_acc", acc_out, 0);
      end

      // 2. basic accumulate
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, 1'b1, 3, 4, 1'b0);
         chk("basic_acc", acc_out, 12 * i);
         chk("basic_a", a_out, 3);
         chk("basic_b", b_out, 4);
      end

      // 3. hold, including unknown operands while disabled
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 9, -2, 1'b0);
         chk("hold_acc", acc_out, 48);
         chk("hold_a", a_out, 3);
         chk("hold_b", b_out, 4);
      end
      step(1'b0, 1'b0, 0, 0, 1'b1);
      chk("holdx_acc", acc_out, 48);
      chk("holdx_a", a_out, 3);
      chk("holdx_b", b_out, 4);

      // 4. signed operands, most negative values
      step(1'b1, 1'b0, 0, 0, 1'b0);
      step(1'b0, 1'b1, -3, 4, 1'b0);
      chk("signed1_acc", acc_out, -12);
      chk("signed1_a", a_out, -3);
      step(1'b0, 1'b1, -128, -128, 1'b0);
      chk("signed2_acc", acc_out, 16372);
      chk("signed2_b", b_out, -128);

      // 5. wrap-around on the 16-bit accumulator
      step(1'b1, 1'b0, 0, 0, 1'b0);
      step(1'b0, 1'b1, -128, -128, 1'b0);
      chk("wrap1_acc_w", acc_out_w, 16384);
      chk("wrap1_acc", acc_out, 16384);
      step(1'b0, 1'b1, -128, -128, 1'b0);
      chk("wrap2_acc_w", acc_out_w, -32768);
      chk("wrap2_acc", acc_out, 32768);

      // 6. reset mid-accumulation discards the sum
      step(1'b1, 1'b0, 0, 0, 1'b0);
      step(1'b0, 1'b1, 3, 4, 1'b0);
      step(1'b0, 1'b1, 3, 4, 1'b0);
      chk("midrst_pre", acc_out, 24);
      step(1'b1, 1'b1, 3, 4, 1'b0);
      chk("midrst_zero", acc_out, 0);
      chk("midrst_zero_a", a_out, 0);
      step(1'b0, 1'b1, 2, 5, 1'b0);
      chk("midrst_post", acc_out, 10);

      // 7. randomized traffic against the reference model
      step(1'b1, 1'b0, 0, 0, 1'b0);
      for (int i = 0; i < 400; i++) begin
         rr = ($urandom_range(0, 31) == 0);
         re = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 5))
            0: begin ra = -128; rb = -128; end
            1: begin ra = 127;  rb = -128; end
            default: begin
               ra = int'($urandom_range(0, 255)) - 128;
               rb = int'($urandom_range(0, 255)) - 128;
            end
         endcase
         step(rr, re, ra, rb, (!re && !rr && $urandom_range(0, 3) == 0));
         chk_model("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
